// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared constants for the program loader: instruction word width, the HALT
// opcode, loader FSM state encodings and a helper that extracts the opcode
// field from an instruction word.
package program_loader_pkg;

  // Instruction word width and HALT opcode, same values as the CPU's defs.vh.
  localparam int         InstrWidth = 16;
  localparam logic [3:0] OP_HALT    = 4'hF;

  // Loader FSM state encodings.
  localparam int         StateWidth = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HI      = 3'd1;
  localparam logic [2:0] ST_LO      = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  // Opcode field of an instruction word (bits 15:12).
  function automatic logic [3:0] opcode_of(input logic [InstrWidth-1:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader
// Streams a program into instruction memory while the CPU is held in reset.
// Bytes arrive over a valid/ready stream and are assembled big-endian into
// 16-bit words, written to consecutive addresses starting at 0. A session
// ends after a HALT word has been written or when the last address is used
// (the latter sets the sticky overflow flag).
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           begin a load session (only looked at in IDLE)
//   abort           cancel an active session, no write and no done pulse
//   rx_data/valid   incoming byte stream
//   rx_ready        a byte is accepted on this cycle's edge if rx_valid is high
//   imem_wr_en      one-cycle instruction-memory write strobe
//   imem_addr       write address (registered)
//   imem_wr_data    assembled instruction word
//   cpu_hold        holds the CPU in reset for the whole session
//   done            one-cycle pulse at normal session completion
//   overflow        sticky: memory filled before a HALT word was seen
//   word_count      words written this session (registered)
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = InstrWidth
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    imem_wr_en,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [INSTR_WIDTH-1:0]  imem_wr_data,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    overflow,
  output logic [ADDR_WIDTH:0]     word_count
);

  logic [StateWidth-1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            lo_q, lo_d;
  logic                  active;

  assign active = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rx_ready   = 1'b0;
    imem_wr_en = 1'b0;
    done       = 1'b0;

    // abort overrides everything outside IDLE: the strobes stay low, so no
    // byte is consumed, no word is written and no done pulse is produced.
    if (active && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_HI;
            addr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
        ST_HI: begin
          rx_ready = 1'b1;
          if (rx_valid) begin
            hi_d    = rx_data;
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          rx_ready = 1'b1;
          if (rx_valid) begin
            lo_d    = rx_data;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          imem_wr_en = 1'b1;
          count_d    = count_q + (ADDR_WIDTH + 1)'(1);
          // HALT wins over the full-memory check: a HALT in the last slot
          // is a clean finish, not an overflow.
          if (opcode_of({hi_q, lo_q}) == OP_HALT) begin
            state_d = ST_FINISH;
          end else if (addr_q == '1) begin
            overflow_d = 1'b1;
            state_d    = ST_FINISH;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_HI;
          end
        end
        ST_FINISH: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // The CPU is held for every non-IDLE state, so hold rises the cycle after
  // start and falls on the return to IDLE.
  assign cpu_hold     = active;
  assign imem_addr    = addr_q;
  assign imem_wr_data = INSTR_WIDTH'({hi_q, lo_q});
  assign overflow     = overflow_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_wr_en;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wr_data;
  logic          cpu_hold;
  logic          done;
  logic          overflow;
  logic [AW:0]   word_count;

  program_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_wr_data(imem_wr_data),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    logic [7:0]    b_hi;
    logic [7:0]    b_lo;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_data;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expectation.
  task automatic monitor();
    wr_t e;
    if (imem_wr_en) begin
      check("wr_rx_ready_low", 32'(rx_ready), 0);
      check("wr_cpu_hold", 32'(cpu_hold), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write 0x%04h@%0d, required no write", imem_wr_data, imem_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", 32'(imem_wr_data), 32'(e.data));
        $display("write 0x%04h @ %0d (expected 0x%04h @ %0d)", imem_wr_data, imem_addr, e.data, e.addr);
      end
    end
    if (done) n_done++;
  endtask

  task automatic tick(output logic rdy);
    @(negedge clk);
    rdy = rx_ready;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    logic r;
    tick(r);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    logic r;
    bit   ok;
    int   gap;
    ok  = 1'b0;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      step();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick(r);
      if (r) ok = 1'b1;
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got no rx_ready for byte 0x%02h, required acceptance", b);
    end
  endtask

  // Sends a word and checks the write strobe appears the cycle after the low byte.
  task automatic load_word(input logic [15:0] w, input int max_gap);
    send_byte(w[15:8], max_gap);
    send_byte(w[7:0], max_gap);
    check("wr_latency", 32'(imem_wr_en), 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_table(input string tag, input int max_gap);
    int d0;
    d0 = n_done;
    check({tag, "_hold_before"}, 32'(cpu_hold), 0);
    do_start();
    check({tag, "_hold_after_start"}, 32'(cpu_hold), 1);
    check({tag, "_ready_after_start"}, 32'(rx_ready), 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(wr_t'{vecs[i].exp_addr, vecs[i].exp_data});
      send_byte(vecs[i].b_hi, max_gap);
      send_byte(vecs[i].b_lo, max_gap);
      check({tag, "_wr_latency"}, 32'(imem_wr_en), 1);
    end
    check({tag, "_no_done_on_write"}, 32'(done), 0);
    step();
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_hold_at_done"}, 32'(cpu_hold), 1);
    check({tag, "_word_count"}, 32'(word_count), 3);
    check({tag, "_overflow"}, 32'(overflow), 0);
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 0);
    check({tag, "_hold_released"}, 32'(cpu_hold), 0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
    check({tag, "_done_pulses"}, 32'(n_done - d0), 1);
  endtask

  initial begin
    int d0;
    logic [7:0] hb;
    logic [7:0] lb;

    vecs[0] = '{8'h1A, 8'h23, 4'd0, 16'h1A23};
    vecs[1] = '{8'h2B, 8'h01, 4'd1, 16'h2B01};
    vecs[2] = '{{OP_HALT, 4'h0}, 8'h00, 4'd2, 16'hF000};

    reset = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_wr_en", 32'(imem_wr_en), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wr_data", 32'(imem_wr_data), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_word_count", 32'(word_count), 0);
    reset = 1'b0;
    step();

    // Normal load and the same load under random stalls.
    run_table("normal", 0);
    run_table("stall", 3);

    // Overflow: 16 non-HALT words fill a 16-word memory.
    d0 = n_done;
    do_start();
    for (int i = 0; i < 16; i++) begin
      hb = 8'h30 + 8'(i);
      lb = 8'hC0 ^ 8'(i);
      exp_q.push_back(wr_t'{AW'(i), {hb, lb}});
      load_word({hb, lb}, 1);
    end
    step();
    check("ovf_done", 32'(done), 1);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_word_count", 32'(word_count), 16);
    step();
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    #1;
    check("ovf_17th_ready", 32'(rx_ready), 0);
    step();
    check("ovf_17th_ready_later", 32'(rx_ready), 0);
    check("ovf_sticky", 32'(overflow), 1);
    rx_valid = 1'b0;
    check("ovf_writes_left", 32'(exp_q.size()), 0);
    check("ovf_done_pulses", 32'(n_done - d0), 1);

    // Start while in HI is ignored.
    d0 = n_done;
    do_start();
    check("restart_clears_ovf", 32'(overflow), 0);
    exp_q.push_back(wr_t'{4'd0, 16'h4455});
    load_word(16'h4455, 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("hi_start_addr", 32'(imem_addr), 1);
    check("hi_start_count", 32'(word_count), 1);
    check("hi_start_ready", 32'(rx_ready), 1);
    exp_q.push_back(wr_t'{4'd1, 16'hF123});
    load_word(16'hF123, 0);
    step();
    check("hi_start_done", 32'(done), 1);
    check("hi_start_count_end", 32'(word_count), 2);
    step();
    check("hi_start_done_pulses", 32'(n_done - d0), 1);

    // Abort after 1.5 words.
    d0 = n_done;
    do_start();
    exp_q.push_back(wr_t'{4'd0, 16'h1234});
    load_word(16'h1234, 0);
    send_byte(8'h56, 0);
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h78;
    #1;
    check("abort_ready_low", 32'(rx_ready), 0);
    step();
    abort    = 1'b0;
    rx_valid = 1'b0;
    check("abort_hold_low", 32'(cpu_hold), 0);
    check("abort_word_count", 32'(word_count), 1);
    step();
    step();
    check("abort_no_done", 32'(n_done - d0), 0);
    do_start();
    check("abort_restart_count", 32'(word_count), 0);
    // Abort landing on a WRITE cycle suppresses the strobe.
    load_word(16'hABCD, 0);
    abort = 1'b1;
    #1;
    check("abort_write_suppressed", 32'(imem_wr_en), 0);
    step();
    abort = 1'b0;
    check("abort_write_count", 32'(word_count), 0);
    check("abort_write_hold", 32'(cpu_hold), 0);
    check("abort_writes_left", 32'(exp_q.size()), 0);

    // Asynchronous reset while in LO.
    do_start();
    send_byte(8'h11, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rx_ready", 32'(rx_ready), 0);
    check("arst_cpu_hold", 32'(cpu_hold), 0);
    check("arst_wr_data", 32'(imem_wr_data), 0);
    check("arst_addr", 32'(imem_addr), 0);
    check("arst_word_count", 32'(word_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d0 = n_done;
    do_start();
    exp_q.push_back(wr_t'{4'd0, 16'h2233});
    load_word(16'h2233, 0);
    exp_q.push_back(wr_t'{4'd1, 16'hF0FF});
    load_word(16'hF0FF, 0);
    step();
    check("arst_reload_done", 32'(done), 1);
    check("arst_reload_count", 32'(word_count), 2);
    step();
    check("arst_reload_pulses", 32'(n_done - d0), 1);
    check("final_writes_left", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
